// File: rtl/led_pattern_sequencer_if.sv
// Bus bundle for the LED pattern sequencer: pattern RAM write port,
// playback controls and the status outputs it reports back.
interface led_pattern_sequencer_if #(
    parameter int WIDTH  = 5,
    parameter int ADDR_W = 4
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_data;
    logic [ADDR_W-1:0] last;
    logic [1:0]        mode;
    logic              start;
    logic              run;
    logic [WIDTH-1:0]  led;
    logic [ADDR_W-1:0] idx;
    logic              tick;
    logic              done;

    modport master (
        output wr_en, wr_addr, wr_data, last, mode, start, run,
        input  led, idx, tick, done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, last, mode, start, run,
        output led, idx, tick, done
    );
endinterface

// File: rtl/led_pattern_sequencer.sv
// LED pattern player: steps through a writable pattern RAM on a prescaled
// tick with loop, ping-pong and one-shot playback.
module led_pattern_sequencer #(
    parameter int WIDTH    = 5,
    parameter int ADDR_W   = 4,
    parameter int DIV_BITS = 21
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    led_pattern_sequencer_if.slave  bus
);
    localparam int         DEPTH         = 2 ** ADDR_W;
    localparam logic [1:0] MODE_PINGPONG = 2'd1;
    localparam logic [1:0] MODE_ONESHOT  = 2'd2;

    typedef enum logic [1:0] {
        IDLE,
        UP,
        DOWN,
        FIN
    } state_e;

    logic [WIDTH-1:0]    mem_q [DEPTH];
    state_e              state_q, state_d;
    logic [DIV_BITS-1:0] prescale_q, prescale_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]    led_q, led_d;
    logic                tick_q, tick_d;
    logic                done_q, done_d;
    logic                at_end;

    // Pattern RAM is never reset and accepts writes even while reset is held;
    // the non-blocking write gives read-first behaviour for a same-cycle step.
    always_ff @(posedge clk_i) begin
        if (bus.wr_en) begin
            mem_q[bus.wr_addr] <= bus.wr_data;
        end
    end

    assign at_end = (idx_q >= bus.last);

    always_comb begin
        state_d    = state_q;
        prescale_d = prescale_q;
        idx_d      = idx_q;
        led_d      = led_q;
        tick_d     = 1'b0;
        done_d     = done_q;

        if (bus.start) begin
            state_d    = UP;
            prescale_d = '0;
            idx_d      = '0;
            done_d     = 1'b0;
        end else begin
            case (state_q)
                UP, DOWN: begin
                    if (bus.run) begin
                        prescale_d = prescale_q + DIV_BITS'(1);
                        if (prescale_q == '1) begin
                            led_d  = mem_q[idx_q];
                            tick_d = 1'b1;
                            // DOWN only persists while ping-pong is selected;
                            // any other mode decodes from the current index as UP.
                            if ((state_q == DOWN) && (bus.mode == MODE_PINGPONG)) begin
                                if (idx_q == '0) begin
                                    state_d = UP;
                                    idx_d   = (bus.last == '0) ? '0 : ADDR_W'(1);
                                end else begin
                                    idx_d = idx_q - ADDR_W'(1);
                                end
                            end else begin
                                state_d = UP;
                                if (!at_end) begin
                                    idx_d = idx_q + ADDR_W'(1);
                                end else begin
                                    case (bus.mode)
                                        MODE_PINGPONG: begin
                                            if (bus.last == '0) begin
                                                idx_d = '0;
                                            end else begin
                                                state_d = DOWN;
                                                idx_d   = bus.last - ADDR_W'(1);
                                            end
                                        end
                                        MODE_ONESHOT: begin
                                            state_d = FIN;
                                            done_d  = 1'b1;
                                        end
                                        default: idx_d = '0;
                                    endcase
                                end
                            end
                        end
                    end
                end
                default: prescale_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            prescale_q <= '0;
            idx_q      <= '0;
            led_q      <= '0;
            tick_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            prescale_q <= prescale_d;
            idx_q      <= idx_d;
            led_q      <= led_d;
            tick_q     <= tick_d;
            done_q     <= done_d;
        end
    end

    assign bus.led  = led_q;
    assign bus.idx  = idx_q;
    assign bus.tick = tick_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed bench for led_pattern_sequencer with DIV_BITS=2 (one step every
// 4 cycles); outputs are sampled on the falling edge.
module tb_led_pattern_sequencer;
    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   tickCount;

    led_pattern_sequencer_if #(.WIDTH(5), .ADDR_W(4)) bus ();

    led_pattern_sequencer #(
        .WIDTH(5),
        .ADDR_W(4),
        .DIV_BITS(2)
    ) dut (
        .clk_i(clk),
        .reset_i(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] addr, input logic [4:0] data);
        bus.wr_en   = 1'b1;
        bus.wr_addr = addr;
        bus.wr_data = data;
        @(negedge clk);
        bus.wr_en   = 1'b0;
    endtask

    task automatic pulseStart();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Entered with the prescaler at 0: three quiet cycles, then the step.
    task automatic stepAndCheck(input string tag, input logic [4:0] expLed, input logic [3:0] expIdx);
        repeat (3) begin
            @(negedge clk);
            checkOutput({tag, "-tickLow"}, {31'b0, bus.tick}, 32'd0);
        end
        @(negedge clk);
        checkOutput({tag, "-tick"}, {31'b0, bus.tick}, 32'd1);
        checkOutput({tag, "-led"}, {27'b0, bus.led}, {27'b0, expLed});
        checkOutput({tag, "-idx"}, {28'b0, bus.idx}, {28'b0, expIdx});
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        bus.wr_en = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.last  = 4'd3;
        bus.mode  = 2'd0;
        bus.start = 1'b0;
        bus.run   = 1'b1;

        // RAM is loaded while reset is held
        applyStimulus(4'd0, 5'h01);
        applyStimulus(4'd1, 5'h02);
        applyStimulus(4'd2, 5'h04);
        applyStimulus(4'd3, 5'h08);
        reset = 1'b0;

        tickCount = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.tick) tickCount++;
        end
        checkOutput("idle-ticks", tickCount, 0);
        checkOutput("idle-led", {27'b0, bus.led}, 32'h0);
        checkOutput("idle-idx", {28'b0, bus.idx}, 32'h0);
        checkOutput("idle-done", {31'b0, bus.done}, 32'h0);

        // Loop playback
        pulseStart();
        stepAndCheck("loop1", 5'h01, 4'd1);
        stepAndCheck("loop2", 5'h02, 4'd2);
        stepAndCheck("loop3", 5'h04, 4'd3);
        stepAndCheck("loop4", 5'h08, 4'd0);
        stepAndCheck("loop5", 5'h01, 4'd1);

        // Pause with prescaler at 2, resume finishes the count
        repeat (2) @(negedge clk);
        bus.run = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("pause-led", {27'b0, bus.led}, 32'h01);
        checkOutput("pause-idx", {28'b0, bus.idx}, 32'h1);
        bus.run = 1'b1;
        @(negedge clk);
        checkOutput("resume-tickLow", {31'b0, bus.tick}, 32'd0);
        @(negedge clk);
        checkOutput("resume-tick", {31'b0, bus.tick}, 32'd1);
        checkOutput("resume-led", {27'b0, bus.led}, 32'h02);
        checkOutput("resume-idx", {28'b0, bus.idx}, 32'h2);

        // START on the step edge wins
        repeat (3) @(negedge clk);
        pulseStart();
        checkOutput("prio-idx", {28'b0, bus.idx}, 32'h0);
        checkOutput("prio-tick", {31'b0, bus.tick}, 32'd0);
        checkOutput("prio-led", {27'b0, bus.led}, 32'h02);
        stepAndCheck("prio1", 5'h01, 4'd1);

        // Live RAM edit and LAST lowered while IDX=3
        applyStimulus(4'd1, 5'h1F);
        pulseStart();
        stepAndCheck("edit1", 5'h01, 4'd1);
        stepAndCheck("edit2", 5'h1F, 4'd2);
        stepAndCheck("edit3", 5'h04, 4'd3);
        bus.last = 4'd1;
        stepAndCheck("lastDrop1", 5'h08, 4'd0);
        stepAndCheck("lastDrop2", 5'h01, 4'd1);
        stepAndCheck("lastDrop3", 5'h1F, 4'd0);

        // Ping-pong
        applyStimulus(4'd1, 5'h02);
        bus.last = 4'd3;
        bus.mode = 2'd1;
        pulseStart();
        stepAndCheck("pp1", 5'h01, 4'd1);
        stepAndCheck("pp2", 5'h02, 4'd2);
        stepAndCheck("pp3", 5'h04, 4'd3);
        stepAndCheck("pp4", 5'h08, 4'd2);
        stepAndCheck("pp5", 5'h04, 4'd1);
        stepAndCheck("pp6", 5'h02, 4'd0);
        stepAndCheck("pp7", 5'h01, 4'd1);
        stepAndCheck("pp8", 5'h02, 4'd2);

        // Ping-pong with a single pattern
        bus.last = 4'd0;
        pulseStart();
        stepAndCheck("pp0a", 5'h01, 4'd0);
        stepAndCheck("pp0b", 5'h01, 4'd0);

        // One-shot
        bus.last = 4'd2;
        bus.mode = 2'd2;
        pulseStart();
        stepAndCheck("os1", 5'h01, 4'd1);
        stepAndCheck("os2", 5'h02, 4'd2);
        stepAndCheck("os3", 5'h04, 4'd2);
        checkOutput("os-done", {31'b0, bus.done}, 32'd1);
        tickCount = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.tick) tickCount++;
        end
        checkOutput("fin-ticks", tickCount, 0);
        checkOutput("fin-led", {27'b0, bus.led}, 32'h04);
        checkOutput("fin-done", {31'b0, bus.done}, 32'd1);
        pulseStart();
        checkOutput("restart-done", {31'b0, bus.done}, 32'd0);
        stepAndCheck("restart1", 5'h01, 4'd1);

        // Reset mid-play, RAM survives
        bus.last = 4'd3;
        bus.mode = 2'd0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("rst-led", {27'b0, bus.led}, 32'h0);
        checkOutput("rst-idx", {28'b0, bus.idx}, 32'h0);
        checkOutput("rst-tick", {31'b0, bus.tick}, 32'd0);
        checkOutput("rst-done", {31'b0, bus.done}, 32'd0);
        repeat (8) @(negedge clk);
        checkOutput("rst-idleLed", {27'b0, bus.led}, 32'h0);
        pulseStart();
        stepAndCheck("post1", 5'h01, 4'd1);
        stepAndCheck("post2", 5'h02, 4'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/led_pattern_sequencer.md
Name: led_pattern_sequencer

Overview:
Parametrised LED pattern player for the board-level SOC. It holds a writable pattern RAM and steps through it on an internal prescaled tick, so no separate clock divider is needed. Supports loop, ping-pong and one-shot playback, a programmable sequence length, pause and restart. It drives the board LEDs directly and exposes its index, tick and done status for other SOC logic.

Parameters:
WIDTH, 5, LED / pattern word width in bits
ADDR_W, 4, pattern RAM address width; depth = 2**ADDR_W
DIV_BITS, 21, prescaler width; one tick every 2**DIV_BITS CLK cycles (minimum 1)

Ports:
CLK  in  1  system clock; all logic on posedge
RESET  in  1  synchronous, active-high reset
WR_EN  in  1  pattern RAM write strobe
WR_ADDR  in  ADDR_W  RAM write address
WR_DATA  in  WIDTH  RAM write data
LAST  in  ADDR_W  index of final pattern in sequence (sequence length = LAST+1)
MODE  in  2  0 loop, 1 ping-pong, 2 one-shot, 3 reserved (behaves as loop)
START  in  1  single-cycle restart pulse
RUN  in  1  level; 0 pauses prescaler and stepping
LED  out  WIDTH  registered pattern output
IDX  out  ADDR_W  index of next pattern to be shown
TICK  out  1  one-cycle pulse, high the cycle after each step
DONE  out  1  high while one-shot sequence complete

Behaviour:
- Clock port CLK; reset port RESET, synchronous, active-high. Only one clock domain.
- Reset values: LED=0, IDX=0, TICK=0, DONE=0, prescaler=0, state=IDLE. RAM is not reset; it is initialised to all zeros at configuration.
- States: IDLE, UP, DOWN, FIN.
- RAM write: on a posedge with WR_EN=1, write WR_DATA to WR_ADDR. Writes are accepted in every state, including during reset. A same-cycle read of the written address returns the old data (read-first).
- START (any state, RESET=0): IDX=0, prescaler=0, DONE=0, state=UP. LED is unchanged. START takes priority over a coincident tick.
- IDLE: prescaler held at 0, nothing steps; the sequencer waits for START.
- Prescaler: increments only in UP/DOWN with RUN=1. A step fires on the edge where the prescaler equals 2**DIV_BITS-1 and RUN=1; the prescaler then wraps to 0.
- With RUN=0 the prescaler and IDX freeze. LED holds. Resuming continues from the frozen count.
- Step: LED <= RAM[IDX]; TICK=1 for exactly the next cycle; IDX advances as below. Comparisons use IDX >= LAST so a LAST lowered mid-play is handled.
- Loop (MODE 0/3), state UP: IDX >= LAST -> IDX=0, else IDX+1.
- Ping-pong (MODE 1):
  - UP: IDX >= LAST -> state=DOWN and IDX=LAST-1; if LAST=0, stay in UP with IDX=0.
  - DOWN: IDX=0 -> state=UP and IDX=1 (or 0 if LAST=0); else IDX-1.
  - End patterns are not repeated. Sequence for LAST=3: 0,1,2,3,2,1,0,1...
- One-shot (MODE 2), state UP: IDX >= LAST -> state=FIN, DONE=1 on the next cycle, IDX held.
- FIN: LED holds the last pattern, no ticks, prescaler=0; only START or RESET leave FIN.
- MODE change mid-play takes effect at the next step. If MODE changes while in DOWN to anything other than 1, the next step decodes as UP rules from the current IDX.
- IDX arithmetic is modulo 2**ADDR_W. With LAST at maximum (2**ADDR_W-1), loop wraps via the LAST compare.
- RESET mid-playback returns all outputs to their reset values on that edge. RAM contents are retained.

Test Plan:
(All scenarios use WIDTH=5, ADDR_W=4, DIV_BITS=2, so one tick every 4 cycles.)
- Reset/idle: RESET 2 cycles, no START for 40 cycles -> LED=0, IDX=0, TICK never high, DONE=0.
- Loop: load RAM[0..3]=01,02,04,08; LAST=3, MODE=0; START, RUN=1 -> LED sequence 01,02,04,08,01,... with a change every 4 cycles; TICK high 1 cycle after each change.
- Ping-pong: same RAM, MODE=1 -> LED 01,02,04,08,04,02,01,02,...; with LAST=0 -> LED stays 01 and TICK keeps pulsing.
- One-shot: MODE=2, LAST=2 -> LED 01,02,04, then DONE=1 and LED holds 04 for 40 cycles; a further START -> DONE=0 and LED=01 after 4 cycles.
- Pause/priority: RUN=0 for 10 cycles mid-sequence -> no LED change, IDX frozen; START coincident with a step edge -> IDX=0 and no TICK.
- Live edits: write RAM[1]=1F during play -> next pass shows 1F; drop LAST from 3 to 1 while IDX=3 in loop -> next step shows RAM[3] and IDX=0; RESET mid-play -> LED=0 and state IDLE, with RAM intact on the next START.
